// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
// Sequencer for a wide unsigned add. One 8-bit add slice (a + b + carry) is
// reused once per clock over NBYTES byte lanes, least-significant lane first.
// The carry between lanes is kept in a register.
//
// Parameters:
//   NBYTES  number of 8-bit lanes (2..16); operand width is 8*NBYTES
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   request; accepted when busy=0 (IDLE or DONE)
//   a, b   in   operands, captured on the accepting edge
//   cin    in   carry-in, captured on the accepting edge
//   busy   out  high while lanes are being processed
//   done   out  one-cycle pulse, sum/cout valid
//   sum    out  result, held until the next accepted start
//   cout   out  carry out of the most significant lane
//   ovf    out  signed overflow (only when SERIAL_ADD_OVF_EN is defined)
//
// Optional feature macro: SERIAL_ADD_OVF_EN adds the registered ovf output.
module serial_add_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [8*NBYTES-1:0] a,
    input  logic [8*NBYTES-1:0] b,
    input  logic                cin,
    output logic                busy,
    output logic                done,
    output logic [8*NBYTES-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
    output logic                ovf,
`endif
    output logic                cout
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic            accept;

    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic            carry_reg;
    logic [IW-1:0]   idx_reg;
    logic            cout_reg;

    logic [7:0]      a_lane [NBYTES];
    logic [7:0]      b_lane [NBYTES];
    logic [7:0]      a_sel;
    logic [7:0]      b_sel;
    logic [8:0]      lane_sum;
    logic            last_lane;

`ifdef SERIAL_ADD_OVF_EN
    logic            ovf_reg;
`endif

    // Split the captured operands into byte lanes; the running lane is then
    // picked with the lane index.
    // Each result lane owns its own register and is only written when the
    // index points at it, so unprocessed lanes keep the previous result.
    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
            logic [7:0] lane_q;

            assign a_lane[gi] = a_reg[8*gi +: 8];
            assign b_lane[gi] = b_reg[8*gi +: 8];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lane_q <= 8'd0;
                end else if (busy && (idx_reg == IW'(gi))) begin
                    lane_q <= lane_sum[7:0];
                end
            end

            assign sum[8*gi +: 8] = lane_q;
        end
    endgenerate

    assign a_sel     = a_lane[idx_reg];
    assign b_sel     = b_lane[idx_reg];
    assign lane_sum  = {1'b0, a_sel} + {1'b0, b_sel} + {8'd0, carry_reg};
    assign last_lane = (idx_reg == LAST_IDX);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and handshake outputs. DONE accepts a new start directly so
    // back-to-back operations have no idle cycle between them.
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_lane) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, lane index, inter-lane carry and final flags.
    // The index wraps back to 0 on the last lane so it never leaves
    // the 0..NBYTES-1 range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            idx_reg   <= '0;
            cout_reg  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_reg   <= 1'b0;
`endif
        end else if (accept) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            idx_reg   <= '0;
        end else if (busy) begin
            carry_reg <= lane_sum[8];
            if (last_lane) begin
                idx_reg  <= '0;
                cout_reg <= lane_sum[8];
`ifdef SERIAL_ADD_OVF_EN
                // Same-sign operands giving a result of the other sign
                ovf_reg  <= (a_sel[7] == b_sel[7]) && (lane_sum[7] != a_sel[7]);
`endif
            end else begin
                idx_reg <= idx_reg + IW'(1);
            end
        end
    end

    assign cout = cout_reg;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf  = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl (NBYTES=4). Directed operations with
// hand-computed results, plus a transaction-level model (whole-word add,
// fixed latency) compared against the outputs on every cycle.
module tb_serial_add_ctrl;

    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    serial_add_ctrl #(.NBYTES(NBYTES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
`ifdef SERIAL_ADD_OVF_EN
        .ovf   (ovf),
`endif
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction model: an accepted op produces the full-width sum
    // NBYTES cycles later (busy for NBYTES cycles, then one done cycle).
    // A start is taken whenever no operation is outstanding.
    // ------------------------------------------------------------------
    int           m_rem  = 0;
    bit           m_done = 1'b0;
    logic [W:0]   m_pend = '0;
    bit           m_pend_ovf = 1'b0;
    logic [W-1:0] e_sum  = '0;
    bit           e_cout = 1'b0;
    bit           e_ovf  = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        int old_rem;
        if (!rst_n) begin
            m_rem  = 0;
            m_done = 1'b0;
            e_sum  = '0;
            e_cout = 1'b0;
            e_ovf  = 1'b0;
        end else begin
            old_rem = m_rem;
            m_done  = (old_rem == 1);
            if (old_rem > 0) m_rem = old_rem - 1;
            if (m_done) begin
                e_sum  = m_pend[W-1:0];
                e_cout = m_pend[W];
                e_ovf  = m_pend_ovf;
            end
            if (start && old_rem == 0) begin
                m_pend     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                m_pend_ovf = (a[W-1] == b[W-1]) && (m_pend[W-1] != a[W-1]);
                m_rem      = NBYTES;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", busy, (m_rem > 0));
            check("done", done, m_done);
            if (m_rem == 0) begin
                check("sum", sum, e_sum);
                check("cout", cout, e_cout);
`ifdef SERIAL_ADD_OVF_EN
                check("ovf", ovf, e_ovf);
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus helpers (called right after a falling edge)
    // ------------------------------------------------------------------
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        a     = av;
        b     = bv;
        cin   = cv;
        start = 1'b1;
    endtask

    task automatic wait_done(output int lat, output int nbusy);
        bit got;
        lat   = 0;
        nbusy = 0;
        got   = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            if (lat == 0) start = 1'b0;
            lat++;
            if (busy) nbusy++;
            if (done) got = 1'b1;
        end
        check("done_seen", got, 1'b1);
    endtask

    task automatic show(input string name);
        $display("op %-10s sum=0x%08h cout=%0d", name, sum, cout);
    endtask

    int lat;
    int nbusy;

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;

        // Reset asserted mid-cycle, before any rising edge
        #3 rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_sum",  sum,  32'h0);
        check("rst_cout", cout, 1'b0);
`ifdef SERIAL_ADD_OVF_EN
        check("rst_ovf",  ovf,  1'b0);
`endif
        $display("reset    busy=%0d done=%0d sum=0x%08h cout=%0d", busy, done, sum, cout);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 0xFF + 0x01: carry across one lane boundary, latency and busy length
        start_op(32'h0000_00FF, 32'h0000_0001, 1'b0);
        wait_done(lat, nbusy);
        check("t2_latency", lat, NBYTES + 1);
        check("t2_busy_cycles", nbusy, NBYTES);
        check("t2_sum", sum, 32'h0000_0100);
        check("t2_cout", cout, 1'b0);
        show("ff+1");

        // Wrap-around: all ones + 0 + cin
        start_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        wait_done(lat, nbusy);
        check("t3_sum", sum, 32'h0000_0000);
        check("t3_cout", cout, 1'b1);
`ifdef SERIAL_ADD_OVF_EN
        check("t3_ovf", ovf, 1'b0);
`endif
        show("wrap");

        // Signed overflow boundary
        start_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        wait_done(lat, nbusy);
        check("t4a_sum", sum, 32'h8000_0000);
        check("t4a_cout", cout, 1'b0);
`ifdef SERIAL_ADD_OVF_EN
        check("t4a_ovf", ovf, 1'b1);
`endif
        show("7fff+1");

        start_op(32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1);
        wait_done(lat, nbusy);
        check("t4b_sum", sum, 32'h0000_0000);
        check("t4b_cout", cout, 1'b1);
`ifdef SERIAL_ADD_OVF_EN
        check("t4b_ovf", ovf, 1'b0);
`endif
        show("0f0f+f0f0");

        // Start during RUN ignored; start in DONE accepted with no gap
        start_op(32'h0000_00FF, 32'h0000_0001, 1'b0);
        @(negedge clk);
        a     = 32'h1111_1111;
        start = 1'b1;
        wait_done(lat, nbusy);
        check("t5_ignored_lat", lat, NBYTES);
        check("t5_ignored_sum", sum, 32'h0000_0100);
        show("ignored");
        start_op(32'h0000_0002, 32'h0000_0003, 1'b0);
        wait_done(lat, nbusy);
        check("t5_b2b_lat", lat, NBYTES + 1);
        check("t5_b2b_sum", sum, 32'h0000_0005);
        check("t5_b2b_cout", cout, 1'b0);
        show("b2b");

        // Reset in the 2nd RUN cycle, then restart the same op
        start_op(32'h0101_0101, 32'h0101_0101, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_done", done, 1'b0);
        check("t6_rst_sum",  sum,  32'h0);
        check("t6_rst_cout", cout, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("t6_no_done", done, 1'b0);
        end
        $display("op %-10s aborted by reset sum=0x%08h", "0101+0101", sum);
        rst_n = 1'b1;
        start_op(32'h0101_0101, 32'h0101_0101, 1'b0);
        wait_done(lat, nbusy);
        check("t6_sum", sum, 32'h0202_0202);
        check("t6_cout", cout, 1'b0);
        show("restart");

        @(negedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
